// File: rtl/dcache_pkg.sv
// Shared constants, FSM state encoding and address-split helpers for the data cache.
// The optional DCACHE_PERF_CNT_EN feature is implemented in dcache_ctrl, not here.
package dcache_pkg;

  localparam int LINES   = 16;
  localparam int INDEX_W = 4;
  localparam int TAG_W   = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[5:2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:6];
  endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational read port,
// one synchronous write port. Only the valid bits are reset.
module dcache_store
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [31:0]        rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [31:0]        wr_data_i
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (wr_en_i) begin
      r_valid[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_tag[wr_index_i]  <= wr_tag_i;
      r_data[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = r_valid[rd_index_i];
  assign rd_tag_o   = r_tag[rd_index_i];
  assign rd_data_o  = r_data[rd_index_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_PERF_CNT_EN to add the hit_cnt_o / miss_cnt_o performance counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        cpu_read_i,
  input  logic        cpu_write_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_fill;
  logic        r_is_rd;

  logic               w_line_valid;
  logic [TAG_W-1:0]   w_line_tag;
  logic [31:0]        w_line_data;
  logic               w_hit;
  logic               w_rd_req;
  logic               w_wr_req;
  logic               w_ack;
  logic               w_st_we;
  logic [31:0]        w_st_data;
  logic               w_stall;
  logic [31:0]        w_rdata;

  // A simultaneous read and write is handled as a write.
  assign w_wr_req = cpu_write_i;
  assign w_rd_req = cpu_read_i & ~cpu_write_i;
  assign w_hit    = w_line_valid & (w_line_tag == addr_tag(cpu_addr_i));
  assign w_ack    = r_mem_req & mem_ack_i;

  dcache_store u_store (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .rd_index_i (addr_index(cpu_addr_i)),
    .rd_valid_o (w_line_valid),
    .rd_tag_o   (w_line_tag),
    .rd_data_o  (w_line_data),
    .wr_en_i    (w_st_we),
    .wr_index_i (addr_index(r_mem_addr)),
    .wr_tag_i   (addr_tag(r_mem_addr)),
    .wr_data_i  (w_st_data)
  );

  // Refill on every read ack; a write-through only touches the line when it already hits.
  assign w_st_we   = w_ack & ((r_state == RD_MISS) | ((r_state == WR_THRU) & w_hit));
  assign w_st_data = (r_state == RD_MISS) ? mem_rdata_i : r_mem_wdata;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_wr_req) begin
          w_state_next = WR_THRU;
        end else if (w_rd_req && !w_hit) begin
          w_state_next = RD_MISS;
        end
      end
      RD_MISS, WR_THRU: begin
        if (w_ack) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    w_rdata = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_wr_req || (w_rd_req && !w_hit)) begin
          w_stall = 1'b1;
        end else if (w_rd_req) begin
          w_rdata = w_line_data;
        end
      end
      RD_MISS, WR_THRU: w_stall = 1'b1;
      DONE: begin
        if (r_is_rd) begin
          w_rdata = r_fill;
        end
      end
      default: ;
    endcase
  end

  // CPU-facing outputs are forced quiet while reset is held, even with a request present.
  assign stall_o     = rst_n & w_stall;
  assign cpu_rdata_o = rst_n ? w_rdata : 32'd0;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_fill      <= 32'd0;
      r_is_rd     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_state_next != IDLE) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= w_wr_req;
            r_mem_addr <= cpu_addr_i & 32'hFFFF_FFFC;
            r_is_rd    <= ~w_wr_req;
            if (w_wr_req) begin
              r_mem_wdata <= cpu_wdata_i;
            end
          end
        end
        RD_MISS: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_fill    <= mem_rdata_i;
          end
        end
        WR_THRU: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if ((r_state == IDLE) && w_rd_req && w_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if ((r_state == IDLE) && (w_state_next == RD_MISS)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl; a small backing-memory model answers requests.
// Counter checks are compiled in when DCACHE_PERF_CNT_EN is defined.
module tb_dcache_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_read_i = 1'b0;
  logic        cpu_write_i = 1'b0;
  logic [31:0] cpu_addr_i = 32'd0;
  logic [31:0] cpu_wdata_i = 32'd0;
  logic [31:0] cpu_rdata_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        mem_ack_i = 1'b0;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] mem_model [logic [31:0]];

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .cpu_read_i  (cpu_read_i),
    .cpu_write_i (cpu_write_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'hCAFE0000 | a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU transaction: drive the request, answer the memory after wait_n extra cycles,
  // and compare stall length, memory traffic and the returned data.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int wait_n, input int exp_stall,
                        input logic [31:0] exp_rdata, input int exp_ops);
    int stall_cyc;
    int req_cyc;
    int ops;
    bit done;
    logic [31:0] line_addr;
    logic [31:0] seen_rdata;
    stall_cyc  = 0;
    req_cyc    = 0;
    ops        = 0;
    done       = 1'b0;
    seen_rdata = 32'd0;
    line_addr  = addr & 32'hFFFF_FFFC;
    @(negedge clk_i);
    cpu_read_i  = rd;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (!stall_o) begin
        seen_rdata = cpu_rdata_o;
        check({tag, " rdata"}, cpu_rdata_o, exp_rdata);
        check({tag, " req_low"}, {31'd0, mem_req_o}, 32'd0);
        done = 1'b1;
      end else begin
        stall_cyc++;
        if (mem_req_o) begin
          req_cyc++;
          if (req_cyc == 1 || req_cyc == wait_n + 1) begin
            check({tag, " mem_addr"}, mem_addr_o, line_addr);
            check({tag, " mem_we"}, {31'd0, mem_we_o}, {31'd0, wr});
          end
          if (req_cyc == wait_n + 1) begin
            if (mem_we_o) begin
              check({tag, " mem_wdata"}, mem_wdata_o, wdata);
              mem_model[mem_addr_o] = mem_wdata_o;
            end else begin
              mem_rdata_i = mem_rd(mem_addr_o);
            end
            mem_ack_i = 1'b1;
            ops++;
          end
        end
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
      end
    end
    check({tag, " completed"}, {31'd0, done}, 32'd1);
    check({tag, " stall_cycles"}, stall_cyc, exp_stall);
    check({tag, " mem_ops"}, ops, exp_ops);
    @(negedge clk_i);
    cpu_read_i  = 1'b0;
    cpu_write_i = 1'b0;
    $display("[TB] %s rd=%0b wr=%0b addr=%h stall=%0d mem_ops=%0d rdata=%h",
             tag, rd, wr, addr, stall_cyc, ops, seen_rdata);
  endtask

  initial begin
    #1;
    check("reset stall", {31'd0, stall_o}, 32'd0);
    check("reset rdata", cpu_rdata_o, 32'd0);
    check("reset mem_req", {31'd0, mem_req_o}, 32'd0);
    check("reset mem_we", {31'd0, mem_we_o}, 32'd0);
    check("reset mem_addr", mem_addr_o, 32'd0);
    check("reset mem_wdata", mem_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    #1;
    check("idle stall", {31'd0, stall_o}, 32'd0);
    check("idle rdata", cpu_rdata_o, 32'd0);

    access("cold_rd_100", 1'b1, 1'b0, 32'h100, 32'd0, 3, 5, 32'hCAFE0100, 1);
    access("hit_rd_100", 1'b1, 1'b0, 32'h100, 32'd0, 0, 0, 32'hCAFE0100, 0);
`ifdef DCACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt_o, 32'd1);
    check("miss_cnt", miss_cnt_o, 32'd1);
`endif
    access("wr_hit_100", 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1, 3, 32'd0, 1);
    check("mem_100_written", mem_rd(32'h100), 32'hDEADBEEF);
    access("rd_after_wr_100", 1'b1, 1'b0, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF, 0);
    access("rd_low_bits_103", 1'b1, 1'b0, 32'h103, 32'd0, 0, 0, 32'hDEADBEEF, 0);
    access("wr_miss_200", 1'b0, 1'b1, 32'h200, 32'h12345678, 0, 2, 32'd0, 1);
    access("rd_miss_200", 1'b1, 1'b0, 32'h200, 32'd0, 2, 4, 32'h12345678, 1);
    access("rd_miss_040", 1'b1, 1'b0, 32'h040, 32'd0, 0, 2, 32'hCAFE0040, 1);
    access("rd_miss_440", 1'b1, 1'b0, 32'h440, 32'd0, 1, 3, 32'hCAFE0440, 1);
    access("rd_evicted_040", 1'b1, 1'b0, 32'h040, 32'd0, 0, 2, 32'hCAFE0040, 1);
    access("rd_hit_040", 1'b1, 1'b0, 32'h040, 32'd0, 0, 0, 32'hCAFE0040, 0);
    access("rdwr_both_040", 1'b1, 1'b1, 32'h040, 32'h0BADF00D, 0, 2, 32'd0, 1);
    access("rd_hit_040_new", 1'b1, 1'b0, 32'h040, 32'd0, 0, 0, 32'h0BADF00D, 0);

    // Reset in the middle of a read miss, then a stray ack.
    @(negedge clk_i);
    cpu_read_i = 1'b1;
    cpu_addr_i = 32'h080;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check("rst_mid pre req", {31'd0, mem_req_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mid stall", {31'd0, stall_o}, 32'd0);
    check("rst_mid addr", mem_addr_o, 32'd0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h55AA55AA;
    @(negedge clk_i);
    mem_ack_i   = 1'b0;
    cpu_read_i  = 1'b0;
    rst_n       = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    #1;
    check("late_ack stall", {31'd0, stall_o}, 32'd0);
    check("late_ack req", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk_i);
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'd0;
    #1;
    check("late_ack idle rdata", cpu_rdata_o, 32'd0);
    access("rd_080_after_rst", 1'b1, 1'b0, 32'h080, 32'd0, 0, 2, 32'hCAFE0080, 1);
    access("rd_hit_080", 1'b1, 1'b0, 32'h080, 32'd0, 0, 0, 32'hCAFE0080, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk_i is the clock and rst_n is the reset.
REQ-002 SHALL have port clk_i, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port cpu_read_i, input, 1 bit: MEM-stage load request.
REQ-005 SHALL have port cpu_write_i, input, 1 bit: MEM-stage store request.
REQ-006 SHALL have port cpu_addr_i, input, 32 bits: byte address; bits [1:0] ignored.
REQ-007 SHALL have port cpu_wdata_i, input, 32 bits: store data.
REQ-008 SHALL have port cpu_rdata_o, output, 32 bits: load data.
REQ-009 SHALL have port stall_o, output, 1 bit: request not yet complete; the pipeline freezes.
REQ-010 SHALL have ports mem_req_o (output, 1 bit), mem_we_o (output, 1 bit), mem_addr_o (output, 32 bits) and mem_wdata_o (output, 32 bits): backing-memory request.
REQ-011 SHALL have ports mem_rdata_i (input, 32 bits) and mem_ack_i (input, 1 bit): backing-memory response.

Function
REQ-012 SHALL be a direct-mapped, 16-line cache with 1 word per line, write-through and no-write-allocate.
REQ-013 SHALL split the address as index = addr[5:2] and tag = addr[31:6].
REQ-014 SHALL implement FSM states IDLE, RD_MISS, WR_THRU and DONE.
REQ-015 IDLE, read hit (valid and tag match): cpu_rdata_o = line data combinationally; stall_o = 0; zero-cycle latency.
REQ-016 IDLE, read miss: stall_o = 1 combinationally; next state RD_MISS.
REQ-017 IDLE, write: stall_o = 1 combinationally; next state WR_THRU.
REQ-018 cpu_read_i and cpu_write_i both high SHALL be treated as a write.
REQ-019 RD_MISS: mem_req_o = 1 and mem_we_o = 0, with mem_addr_o = {cpu_addr_i[31:2], 2'b00}, registered on entry.
REQ-020 RD_MISS, on mem_ack_i: write the line (valid = 1, tag, data = mem_rdata_i); latch mem_rdata_i into the fill register; next state DONE.
REQ-021 WR_THRU: mem_req_o = 1, mem_we_o = 1, mem_wdata_o = cpu_wdata_i registered on entry.
REQ-022 WR_THRU, on mem_ack_i: if the line hits, update its data, otherwise leave the line unchanged; next state DONE.
REQ-023 mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL stay stable from state entry until the ack cycle inclusive; mem_req_o drops the cycle after ack.
REQ-024 mem_ack_i SHALL be ignored while mem_req_o = 0.
REQ-025 DONE: stall_o = 0; cpu_rdata_o = fill register (read) or 0 (write); next state IDLE unconditionally.
REQ-026 DONE SHALL not start a new access, even if a request is present.
REQ-027 Miss or write latency SHALL be 2 + N cycles, where N is the memory wait in cycles until ack.
REQ-028 The CPU holds all cpu_* inputs stable while stall_o = 1; the block does not re-check them mid-transaction.
REQ-029 With no request in IDLE: stall_o = 0 and cpu_rdata_o = 0.

Reset
REQ-030 While rst_n = 0, asynchronously: state = IDLE; all valid bits = 0; mem_req_o = 0; mem_we_o = 0; mem_addr_o = 0; mem_wdata_o = 0; fill register = 0; stall_o = 0; cpu_rdata_o = 0.
REQ-031 Reset during RD_MISS or WR_THRU SHALL abandon the transaction with no line update; a late mem_ack_i after reset is ignored.
REQ-032 Tag and data arrays SHALL need no reset.

Configuration
REQ-033 With DCACHE_PERF_CNT_EN defined: outputs hit_cnt_o and miss_cnt_o, 32 bits each, are present.
REQ-034 With DCACHE_PERF_CNT_EN defined: hit_cnt_o increments once per IDLE read hit; miss_cnt_o increments once per RD_MISS entry.
REQ-035 With DCACHE_PERF_CNT_EN defined: both counters wrap at 2^32, reset to 0, and do not count writes.
REQ-036 Without DCACHE_PERF_CNT_EN: no counter ports and no counter logic.

Structure
REQ-037 Shared package dcache_pkg SHALL hold: LINES = 16, INDEX_W = 4, TAG_W = 26, the FSM state enum, and index/tag extraction helpers.
REQ-038 Sub-module dcache_store SHALL hold the valid/tag/data arrays, with 1 combinational read port and 1 synchronous write port.

Verification
REQ-039 Cold read of 0x100 with ack after 3 cycles -> stall_o high for 5 cycles; mem_addr_o = 0x100; cpu_rdata_o = mem value in DONE.
REQ-040 Repeat the read of 0x100 -> stall_o = 0, correct data the same cycle, no mem_req_o; hit counter = 1 (with DCACHE_PERF_CNT_EN).
REQ-041 Write 0xDEADBEEF to 0x100 (hit), then read 0x100 -> one mem write with we = 1; the read hits and returns 0xDEADBEEF.
REQ-042 Write 0x12345678 to 0x200 (miss), then read 0x200 -> the write does not allocate; the read misses and refills.
REQ-043 Read 0x040, then read 0x440 (same index, different tag) -> the second access misses; a read of 0x040 then misses again (eviction).
REQ-044 Assert rst_n low during RD_MISS before ack, then pulse ack -> mem_req_o drops immediately; the next read of that address misses.
